// File: rtl/axis_32to8.sv
// AXI4-Stream 32-bit to 8-bit width down-converter with tkeep-aware partial last words.
// Optional build macro AXIS_32TO8_KEEP_CHECK_EN drops non-contiguous tkeep words and flags them on keep_err_out.
module axis_32to8 #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] axis_tdata_in,
    input  logic [3:0]  axis_tkeep_in,
    input  logic        axis_tvalid_in,
    input  logic        axis_tlast_in,
    output logic        axis_tready_out,
    output logic [7:0]  axis_tdata_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in,
    output logic        keep_err_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam bit MSB_FIRST_B = (MSB_FIRST != 32'sd0);
`ifdef AXIS_32TO8_KEEP_CHECK_EN
    localparam bit KEEP_CHECK_EN = 1'b1;
`else
    localparam bit KEEP_CHECK_EN = 1'b0;
`endif

    logic [0:0]  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  top_q, top_d;      // highest kept lane of the held word (nbytes-1)
    logic        last_q, last_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        keep_err_q, keep_err_d;

    logic        ready_s, in_fire_s, out_fire_s, cur_final_s, in_legal_s;
    logic [1:0]  in_top_s, in_first_s, step_lane_s;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] keep_top(input logic [3:0] k);
        logic [1:0] t;
        casez (k)
            4'b1???: t = 2'd3;
            4'b01??: t = 2'd2;
            4'b001?: t = 2'd1;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    function automatic logic keep_legal(input logic [3:0] k);
        logic ok;
        if (KEEP_CHECK_EN) begin
            case (k)
                4'b0001, 4'b0011, 4'b0111, 4'b1111: ok = 1'b1;
                default:                            ok = 1'b0;
            endcase
        end else begin
            ok = (k != 4'b0000);
        end
        return ok;
    endfunction

    function automatic logic final_lane(input logic [1:0] lane, input logic [1:0] top);
        return MSB_FIRST_B ? (lane == 2'd0) : (lane == top);
    endfunction

    // Handshake decode; ready is forced low while reset is held
    always_comb begin
        cur_final_s = final_lane(lane_q, top_q);
        out_fire_s  = tvalid_q && axis_tready_in;
        ready_s     = !reset && ((state_q == ST_IDLE) || (out_fire_s && cur_final_s));
        in_fire_s   = axis_tvalid_in && ready_s;
        in_top_s    = keep_top(axis_tkeep_in);
        in_legal_s  = keep_legal(axis_tkeep_in);
        in_first_s  = MSB_FIRST_B ? in_top_s : 2'd0;
        step_lane_s = MSB_FIRST_B ? (lane_q - 2'd1) : (lane_q + 2'd1);
    end

    // Next-state: advance lanes on output fire, then let a same-cycle input fire reload the word
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        top_d      = top_q;
        last_d     = last_q;
        lane_d     = lane_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        keep_err_d = 1'b0;

        if (out_fire_s && !cur_final_s) begin
            lane_d  = step_lane_s;
            tdata_d = lane_byte(word_q, step_lane_s);
            tlast_d = last_q && final_lane(step_lane_s, top_q);
        end else if (out_fire_s) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            state_d = state_q;
        end

        if (in_fire_s && in_legal_s) begin
            state_d  = ST_SEND;
            word_d   = axis_tdata_in;
            top_d    = in_top_s;
            last_d   = axis_tlast_in;
            lane_d   = in_first_s;
            tdata_d  = lane_byte(axis_tdata_in, in_first_s);
            tvalid_d = 1'b1;
            tlast_d  = axis_tlast_in && (in_top_s == 2'd0);
        end else if (in_fire_s) begin
            keep_err_d = KEEP_CHECK_EN;
        end else begin
            keep_err_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= 32'h0000_0000;
            top_q      <= 2'd0;
            last_q     <= 1'b0;
            lane_q     <= 2'd0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            keep_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            top_q      <= top_d;
            last_q     <= last_d;
            lane_q     <= lane_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            keep_err_q <= keep_err_d;
        end
    end

    assign axis_tready_out = ready_s;
    assign axis_tdata_out  = tdata_q;
    assign axis_tvalid_out = tvalid_q;
    assign axis_tlast_out  = tlast_q;
    assign keep_err_out    = keep_err_q;

endmodule

// File: tb/tb_axis_32to8.sv
// Directed self-checking bench for axis_32to8 (MSB_FIRST=1); honours AXIS_32TO8_KEEP_CHECK_EN.
module tb_axis_32to8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tdata_in;
    logic [3:0]  tkeep_in;
    logic        tvalid_in, tlast_in, tready_in;
    logic        tready_out, tvalid_out, tlast_out, keep_err;
    logic [7:0]  tdata_out;

    int checks = 0;
    int errors = 0;
    int kerr_cnt = 0;
    int cyc = 0;
    logic [7:0] cap_data[$];
    logic       cap_last[$];
    int         cap_cyc[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    axis_32to8 #(.MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset),
        .axis_tdata_in(tdata_in), .axis_tkeep_in(tkeep_in),
        .axis_tvalid_in(tvalid_in), .axis_tlast_in(tlast_in),
        .axis_tready_out(tready_out),
        .axis_tdata_out(tdata_out), .axis_tvalid_out(tvalid_out),
        .axis_tlast_out(tlast_out), .axis_tready_in(tready_in),
        .keep_err_out(keep_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: capture fired bytes, count error pulses, verify stability under stall
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", tvalid_out, 1'b1);
                check("stall_data", tdata_out, prev_data);
                check("stall_last", tlast_out, prev_last);
            end
            if (tvalid_out && tready_in) begin
                cap_data.push_back(tdata_out);
                cap_last.push_back(tlast_out);
                cap_cyc.push_back(cyc);
            end
            if (keep_err) kerr_cnt++;
            prev_stall = tvalid_out && !tready_in;
            prev_data  = tdata_out;
            prev_last  = tlast_out;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        logic acc;
        tvalid_in = 1'b1; tdata_in = d; tkeep_in = k; tlast_in = l;
        n = 0; acc = 1'b0;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = tready_out;
            @(posedge clk); #1;
            n++;
        end
        check("accept", acc, 1'b1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (tvalid_out && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("idle", tvalid_out, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic expect_bytes(input string tag, input int n, input logic [63:0] bytes, input logic [7:0] lastm);
        int sz;
        sz = cap_data.size();
        check({tag, "_cnt"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            check({tag, "_data"}, cap_data[i], bytes[8*(n-1-i) +: 8]);
            check({tag, "_last"}, cap_last[i], lastm[i]);
        end
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    initial begin
        int pat[7];
        pat = '{1, 0, 0, 1, 0, 1, 1};
        reset = 1'b1; tvalid_in = 1'b0; tdata_in = 32'h0; tkeep_in = 4'h0;
        tlast_in = 1'b0; tready_in = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", tready_out, 1'b0);
        check("rst_valid", tvalid_out, 1'b0);
        check("rst_last", tlast_out, 1'b0);
        check("rst_data", tdata_out, 8'h00);
        check("rst_kerr", keep_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", tready_out, 1'b1);
        @(posedge clk); #1;

        // Full word: A1,B2,C3,D4 with tready_out low for three cycles
        send_word(32'hA1B2C3D4, 4'b1111, 1'b1);
        tvalid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_ready", tready_out, (i == 3) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end
        wait_idle();
        expect_bytes("t1", 4, 64'hA1B2C3D4, 8'b0000_1000);

        // Back-to-back words with no bubble
        send_word(32'h01020304, 4'b1111, 1'b0);
        send_word(32'h05060708, 4'b1111, 1'b1);
        tvalid_in = 1'b0;
        wait_idle();
        if (cap_cyc.size() == 8) check("b2b_span", cap_cyc[7] - cap_cyc[0], 7);
        else check("b2b_size", cap_cyc.size(), 8);
        expect_bytes("b2b", 8, 64'h0102030405060708, 8'b1000_0000);

        // Partial words
        send_word(32'h00001122, 4'b0011, 1'b1);
        tvalid_in = 1'b0;
        wait_idle();
        expect_bytes("p2", 2, 64'h1122, 8'b0000_0010);
        send_word(32'h000000EE, 4'b0001, 1'b1);
        tvalid_in = 1'b0;
        wait_idle();
        expect_bytes("p1", 1, 64'hEE, 8'b0000_0001);

        // Stalled output
        send_word(32'h11223344, 4'b1111, 1'b1);
        tvalid_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tready_in = pat[i][0];
            @(posedge clk); #1;
        end
        tready_in = 1'b1;
        wait_idle();
        expect_bytes("stall", 4, 64'h11223344, 8'b0000_1000);

        // Holey tkeep
        kerr_cnt = 0;
        send_word(32'h00AABBCC, 4'b0101, 1'b0);
        tvalid_in = 1'b0;
        wait_idle();
`ifdef AXIS_32TO8_KEEP_CHECK_EN
        expect_bytes("k0101", 0, 64'h0, 8'h00);
        check("k0101_kerr", kerr_cnt, 1);
`else
        expect_bytes("k0101", 3, 64'hAABBCC, 8'h00);
        check("k0101_kerr", kerr_cnt, 0);
`endif

        // Empty tkeep with tlast is dropped
        kerr_cnt = 0;
        send_word(32'h12345678, 4'b0000, 1'b1);
        tvalid_in = 1'b0;
        wait_idle();
        expect_bytes("k0000", 0, 64'h0, 8'h00);
`ifdef AXIS_32TO8_KEEP_CHECK_EN
        check("k0000_kerr", kerr_cnt, 1);
`else
        check("k0000_kerr", kerr_cnt, 0);
`endif

        // Reset during the second byte
        send_word(32'h11223344, 4'b1111, 1'b1);
        tvalid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rmid_valid", tvalid_out, 1'b0);
        check("rmid_ready", tready_out, 1'b0);
        check("rmid_last", tlast_out, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        expect_bytes("rmid", 1, 64'h11, 8'h00);
        @(posedge clk); #1;
        send_word(32'hDEADBEEF, 4'b1111, 1'b1);
        tvalid_in = 1'b0;
        wait_idle();
        expect_bytes("post_rst", 4, 64'hDEADBEEF, 8'b0000_1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
